button_matrix_scanner: RTL and testbench

Scans an N×N push-button matrix one column at a time, debounces each switch and presents the result as an N*N cell vector. It is the input-side counterpart of the LED array driver: both use the same bit layout, so one scan frame can seed or edit the Conway grid directly. It sits between the board's button-matrix pins and the game-of-life core.

---
 rtl/button_matrix_scanner_if.sv | 27 ++
 rtl/button_matrix_scanner.sv | 138 +++++++++++++
 tb/tb_button_matrix_scanner.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_matrix_scanner_if.sv
// Bus between the button-matrix pins/controller and the scanner: enable,
// raw row sense lines in, column drive plus debounced cell image out.
interface button_matrix_scanner_if #(
  parameter int N = 5
);
  localparam int XW = $clog2(N) + 1;

  logic          ena;
  logic [N-1:0]  rows_in;
  logic [N-1:0]  cols_out;
  logic [XW-1:0] x;
  logic [N*N-1:0] cells;
  logic          frame_done;
  logic          changed;

  // Side that enables scanning and owns the row sense lines.
  modport master (
    output ena, rows_in,
    input  cols_out, x, cells, frame_done, changed
  );

  // The scanner itself.
  modport slave (
    input  ena, rows_in,
    output cols_out, x, cells, frame_done, changed
  );
endinterface

// File: rtl/button_matrix_scanner.sv
// Column-at-a-time scanner for an N x N push-button matrix. Each column is
// driven for SETTLE_CYCLES, then the synchronized rows are shifted into
// per-cell histories; a cell only flips once its last DEBOUNCE_SCANS samples
// agree. Cell c = column*N + row, the same layout the LED array driver uses.
module button_matrix_scanner #(
  parameter int N              = 5,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic rst,
  button_matrix_scanner_if.slave bus
);
  localparam int XW = $clog2(N) + 1;
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam int NC = N * N;
  localparam int D  = DEBOUNCE_SCANS;
  localparam logic [N-1:0] ONE = 1;

  if (N < 1 || N > 8) begin : gBadN
    $error("button_matrix_scanner: N must be in 1..8");
  end
  if (SETTLE_CYCLES < 1) begin : gBadSettle
    $error("button_matrix_scanner: SETTLE_CYCLES must be >= 1");
  end
  if (DEBOUNCE_SCANS < 1) begin : gBadDebounce
    $error("button_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t                state_q;
  logic [N-1:0]          sync1_q;
  logic [N-1:0]          rowsSync_q;
  logic [N-1:0]          cols_q;
  logic [XW-1:0]         x_q;
  logic [XW-1:0]         xNext_d;
  logic [CW-1:0]         cnt_q;
  logic [NC-1:0]         cells_q;
  logic [NC-1:0]         cells_d;
  logic [NC-1:0][D-1:0]  hist_q;
  logic [NC-1:0][D-1:0]  hist_d;
  logic                  frameDone_q;
  logic                  changed_q;
  logic                  sticky_q;
  logic                  anyMod_d;
  logic                  lastCol_d;

  // Per-cell next history and debounced value; only the column under x
  // moves, everything else holds, so this is only committed in SAMPLE.
  for (genvar c = 0; c < NC; c++) begin : gCell
    localparam int COL = c / N;
    localparam int ROW = c % N;
    logic         colHit;
    logic [D:0]   ext;
    logic [D-1:0] shifted;

    assign colHit     = (x_q == XW'(COL));
    assign ext        = {hist_q[c], rowsSync_q[ROW]};
    assign shifted    = ext[D-1:0];
    assign hist_d[c]  = colHit ? shifted : hist_q[c];
    assign cells_d[c] = !colHit    ? cells_q[c] :
                        (&shifted) ? 1'b1 :
                        (|shifted) ? cells_q[c] : 1'b0;
  end

  assign anyMod_d  = |(cells_d ^ cells_q);
  assign lastCol_d = (x_q == XW'(N - 1));
  assign xNext_d   = lastCol_d ? '0 : x_q + XW'(1);

  // Synchronizer, column sequencer, debounce commit and frame reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      rowsSync_q  <= '0;
      cols_q      <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      cells_q     <= '0;
      hist_q      <= '0;
      frameDone_q <= 1'b0;
      changed_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      sync1_q     <= bus.rows_in;
      rowsSync_q  <= sync1_q;
      frameDone_q <= 1'b0;
      changed_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ena) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            cols_q  <= ONE << x_q;
          end
        end
        SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SAMPLE: begin
          hist_q  <= hist_d;
          cells_q <= cells_d;
          x_q     <= xNext_d;
          if (lastCol_d) begin
            frameDone_q <= 1'b1;
            changed_q   <= sticky_q | anyMod_d;
            sticky_q    <= 1'b0;
          end else begin
            sticky_q <= sticky_q | anyMod_d;
          end
          if (bus.ena) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            cols_q  <= ONE << xNext_d;
          end else begin
            state_q <= IDLE;
            cols_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cols_q  <= '0;
        end
      endcase
    end
  end

  assign bus.cols_out   = cols_q;
  assign bus.x          = x_q;
  assign bus.cells      = cells_q;
  assign bus.frame_done = frameDone_q;
  assign bus.changed    = changed_q;
endmodule

// File: tb/tb_button_matrix_scanner.sv
// Bench for button_matrix_scanner (N=5, SETTLE=4, DEBOUNCE=3). A key matrix
// model turns held keys plus the column drive into row sense lines; a
// behavioural model tracks column timing and per-cell run lengths and is
// compared with the DUT every cycle, alongside directed literal checks.
module tb_button_matrix_scanner;
  localparam int N  = 5;
  localparam int S  = 4;
  localparam int D  = 3;
  localparam int NC = N * N;
  localparam int XW = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_matrix_scanner_if #(.N(N)) bus ();

  button_matrix_scanner #(
    .N(N), .SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [NC-1:0] keyDown = '0;
  logic [N-1:0]  rowsDrv;
  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  // Physical matrix: a row senses high when a held key sits in a driven column.
  always_comb begin
    rowsDrv = '0;
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        if (bus.cols_out[c] && keyDown[c*N+r]) rowsDrv[r] = 1'b1;
  end
  assign bus.rows_in = rowsDrv;

  // Reference model state: column timing and per-cell agreeing-run lengths.
  bit            checkOn = 0;
  bit            mActive;
  int            mPos;
  int            mX;
  bit            mCells [NC];
  bit            runVal [NC];
  int            runLen [NC];
  logic [N-1:0]  s1, s2, mUsed;
  bit            frameMod;
  logic [N-1:0]  eCols;
  int            eX;
  logic [NC-1:0] eCells;
  bit            eFd, eCh;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic r);
    @(negedge clk);
    bus.ena = e;
    rst     = r;
  endtask

  // Model update on each edge from the inputs present before it.
  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      mActive = 0; mPos = 0; mX = 0; frameMod = 0;
      s1 = '0; s2 = '0;
      for (int c = 0; c < NC; c++) begin
        mCells[c] = 0; runVal[c] = 0; runLen[c] = D;
      end
      eFd = 0; eCh = 0;
      checkOn = 1;
    end else begin
      mUsed = s2;
      s2 = s1;
      s1 = bus.rows_in;
      eFd = 0; eCh = 0;
      if (!mActive) begin
        if (bus.ena) begin mActive = 1; mPos = 0; end
      end else if (mPos < S) begin
        mPos++;
      end else begin
        for (int r = 0; r < N; r++) begin
          int c;
          c = mX * N + r;
          if (mUsed[r] == runVal[c]) begin
            if (runLen[c] < D) runLen[c]++;
          end else begin
            runVal[c] = mUsed[r];
            runLen[c] = 1;
          end
          if (runLen[c] >= D && mCells[c] != runVal[c]) begin
            mCells[c] = runVal[c];
            frameMod = 1;
          end
        end
        if (mX == N - 1) begin
          eFd = 1; eCh = frameMod; frameMod = 0;
        end
        mX = (mX + 1) % N;
        if (bus.ena) mPos = 0; else mActive = 0;
      end
    end
    eCols = mActive ? (5'b00001 << mX) : 5'b00000;
    eX = mX;
    for (int c = 0; c < NC; c++) eCells[c] = mCells[c];
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("cols_out", bus.cols_out, eCols);
      checkOutput("x", bus.x, eX);
      checkOutput("cells", bus.cells, eCells);
      checkOutput("frame_done", bus.frame_done, eFd);
      checkOutput("changed", bus.changed, eCh);
      checkOutput("cols onehot0", $onehot0(bus.cols_out), 1);
    end
  end

  task automatic waitFrameDone();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done) seen = 1;
    end
    checkOutput("frame_done wait", seen, 1);
  endtask

  task automatic waitColumn(input int col);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.x == col && bus.cols_out == (5'b00001 << col)) seen = 1;
    end
    checkOutput("column wait", seen, 1);
  endtask

  bit patKey [8] = '{1, 0, 1, 1, 1, 0, 0, 0};
  bit patExp [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
  int fdCycle [10];
  int pulses;

  initial begin
    bus.ena = 1'b0;
    // Reset and idle
    repeat (2) applyStimulus(0, 1);
    applyStimulus(0, 0);
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.frame_done || bus.changed) pulses++;
    end
    checkOutput("idle pulses", pulses, 0);
    checkOutput("idle cols", bus.cols_out, 0);
    checkOutput("idle x", bus.x, 0);
    checkOutput("idle cells", bus.cells, 0);

    // Single key at column 1, row 2
    keyDown[7] = 1'b1;
    applyStimulus(1, 0);
    repeat (3) waitFrameDone();
    checkOutput("key cells frame3", bus.cells, 32'h80);
    checkOutput("key changed frame3", bus.changed, 1);
    waitFrameDone();
    checkOutput("key cells frame4", bus.cells, 32'h80);
    checkOutput("key changed frame4", bus.changed, 0);

    // Bounce sequence then release
    keyDown = '0;
    applyStimulus(1, 1);
    keyDown[7] = patKey[0];
    applyStimulus(1, 0);
    for (int i = 0; i < 8; i++) begin
      keyDown[7] = patKey[i];
      waitFrameDone();
      checkOutput($sformatf("bounce frame%0d", i + 1), bus.cells[7], patExp[i]);
    end

    // Enable drop during column 2 settle
    waitColumn(2);
    applyStimulus(0, 0);
    begin
      bit idle = 0;
      for (int i = 0; i < 50 && !idle; i++) begin
        @(negedge clk);
        if (bus.cols_out == 0) idle = 1;
      end
      checkOutput("drop reaches idle", idle, 1);
    end
    checkOutput("drop x", bus.x, 3);
    repeat (20) @(negedge clk);
    checkOutput("drop still idle", bus.cols_out, 0);
    applyStimulus(1, 0);
    keyDown[7] = 1'b1;
    @(negedge clk);
    checkOutput("resume cols", bus.cols_out, 5'b01000);

    // Mid-frame reset with cells[7] set
    repeat (4) waitFrameDone();
    checkOutput("pre-reset cell7", bus.cells[7], 1);
    waitColumn(3);
    applyStimulus(1, 1);
    applyStimulus(1, 0);
    checkOutput("reset cells", bus.cells, 0);
    checkOutput("reset x", bus.x, 0);
    checkOutput("reset cols", bus.cols_out, 0);
    @(negedge clk);
    checkOutput("restart cols", bus.cols_out, 5'b00001);

    // All keys held for 10 frames
    keyDown = '1;
    for (int i = 0; i < 10; i++) begin
      waitFrameDone();
      fdCycle[i] = cycle;
      if (i == 2) checkOutput("all cells frame3", bus.cells, 32'h1FFFFFF);
      if (i > 0) checkOutput("frame period", fdCycle[i] - fdCycle[i-1], 25);
    end

    // Randomized keys, enable and occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic e, r;
      e = bus.ena;
      if ($urandom_range(59) == 0) e = ~e;
      r = ($urandom_range(599) == 0);
      applyStimulus(e, r);
      if ($urandom_range(29) == 0) keyDown[$urandom_range(NC-1)] ^= 1'b1;
      if ($urandom_range(299) == 0) keyDown = NC'($urandom);
    end
    applyStimulus(0, 0);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end
endmodule
